// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART transmit byte FIFO.
//   byte_t           : one transmit byte
//   UART_FIFO_DEPTH  : default number of FIFO entries (power of two, >= 2)
//   UART_FIFO_WIDTH  : default data bits per entry
package uart_tx_fifo_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned UART_FIFO_DEPTH = 16;
    localparam int unsigned UART_FIFO_WIDTH = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Stream bundle around the UART transmit FIFO: producer-side AXI-stream,
// UART-side AXI-stream, flush request and status.
//   slave  : the FIFO (sinks in_*, sources out_*, reports count/overflow)
//   master : the environment (core producer + UART consumer)
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             flush;
    logic [WIDTH-1:0] in_tdata;
    logic             in_tvalid;
    logic             in_tready;
    logic [WIDTH-1:0] out_tdata;
    logic             out_tvalid;
    logic             out_tready;
    logic [CW-1:0]    count;
    logic             overflow;

    modport slave (
        input  flush, in_tdata, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tvalid, count, overflow
    );

    modport master (
        output flush, in_tdata, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tvalid, count, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_ram.sv
// FIFO storage: DEPTH x WIDTH, one synchronous write port, one asynchronous
// read port. Kept free of control so it can map onto plain logic or RAM.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module uart_tx_fifo_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the control.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core's transmit-byte source and the UART
// transmitter's AXI-stream input. Show-ahead output, no cut-through.
// Optional drop-on-full mode for producers that cannot stall.
//   clk            : single clock
//   rst            : synchronous, active-high reset
//   bus.flush      : synchronous clear of contents and overflow flag
//   bus.in_*       : producer AXI-stream (in_tready = !full, or 1 when dropping)
//   bus.out_*      : UART-side AXI-stream, out_tdata is the head entry
//   bus.count      : occupancy 0..DEPTH
//   bus.overflow   : sticky, a write was dropped while full
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH          = UART_FIFO_DEPTH,
    parameter int unsigned WIDTH          = UART_FIFO_WIDTH,
    parameter bit          DROP_WHEN_FULL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    // Flags come from the occupancy counter, never from pointer compare.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign bus.in_tready  = DROP_WHEN_FULL ? 1'b1 : !full;
    assign bus.out_tvalid = !empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;

    // Ready is a function of the current count only, so a pop never opens
    // a slot for the same cycle's write.
    assign push = bus.in_tvalid && bus.in_tready && !full;
    assign pop  = !empty && bus.out_tready;
    assign drop = DROP_WHEN_FULL && bus.in_tvalid && full;

    uart_tx_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_tdata),
        .raddr (rd_ptr),
        .rdata (bus.out_tdata)
    );

    // Pointers, occupancy and sticky overflow; rst/flush beat all traffic.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
